lane_wb_arbiter: RTL and testbench
==================================

Name: lane_wb_arbiter

Overview:
Writeback-side collector for one vector lane. It receives per-element results from the lane functional units (ALU, SQRT, EXP, MUL, DIV) over independent valid/ready channels and arbitrates them round-robin onto a single registered register-file write port. It tracks per-unit slice completion and raises a one-cycle done pulse when a unit has written all SLICE_W elements of a slice. It sits between the lane execute stages and the vector register file write port.

Parameters:
NUM_FU, 5, number of functional-unit result channels (index 0 = ALU, 1 = SQRT, 2 = EXP, 3 = MUL, 4 = DIV)
SLICE_W, 16, elements per slice; power of two
ELEM_W, 16, element data width
VREG_W, 6, destination vector register index width
GIDX_W, 10, global element index width
ITER_W, $clog2(SLICE_W), in-slice iteration index width

Ports:
CLK  in  1  clock, rising edge
nRST  in  1  asynchronous active-low reset
flush  in  1  synchronous clear of all state
fu_valid  in  NUM_FU  result valid, one per unit
fu_ready  out  NUM_FU  grant/accept, one per unit
fu_data  in  NUM_FU*ELEM_W  result element
fu_vd  in  NUM_FU*VREG_W  destination register
fu_gidx  in  NUM_FU*GIDX_W  slice base global index
fu_iter  in  NUM_FU*ITER_W  element position within slice
fu_mask  in  NUM_FU  1 = element active (write enabled)
wb_valid  out  1  write port holds an element
wb_ready  in  1  register file accepts this cycle
wb_we  out  1  write enable (captured mask bit)
wb_vd  out  VREG_W  destination register
wb_elem_idx  out  GIDX_W  fu_gidx + fu_iter, modulo 2^GIDX_W
wb_data  out  ELEM_W  element data
wb_src  out  $clog2(NUM_FU)  unit that produced the element
fu_done  out  NUM_FU  one-cycle pulse on slice completion
wb_err  out  1  sticky ordering error

Behaviour:
- Reset (nRST low, asynchronous): every output register is 0 (wb_valid, wb_we, wb_vd, wb_elem_idx, wb_data, wb_src, fu_done, wb_err). rr_ptr = 0. All per-unit counters = 0. fu_ready is combinational and is 0 while no unit is valid.
- Slot free: slot_free = !wb_valid | wb_ready.
- Grant: when slot_free and flush = 0, the granted unit g is the first unit with fu_valid set, searching cyclically from rr_ptr. Only fu_ready[g] = 1. All fu_ready are 0 when the slot is not free or flush = 1. fu_ready does not depend on fu_valid of other units beyond the priority search.
- Transfer: on fu_valid[g] & fu_ready[g], the output register captures data, vd, elem_idx, mask into wb_we, and g into wb_src. Then wb_valid <= 1 and rr_ptr <= (g + 1) mod NUM_FU.
- Latency: 1 cycle from accept to wb_valid. Sustained throughput is 1 element per cycle while wb_ready = 1.
- Hold: while wb_valid = 1 and wb_ready = 0, all wb_* outputs stay stable.
- Drain: if slot_free, no grant and no flush, wb_valid <= 0.
- Masked elements (fu_mask = 0) occupy a write slot with wb_we = 0 and count toward completion.
- Completion counter cnt[i], ITER_W+1 bits, increments on each accept from unit i.
  - On the accept where cnt[i] == SLICE_W-1, cnt[i] wraps to 0 and fu_done[i] is registered.
  - fu_done[i] therefore pulses high in the same cycle that unit's last element first appears on wb_valid, for exactly one cycle, even if wb_ready is low.
- Ordering check: on accept from unit i, fu_iter[i] must equal cnt[i][ITER_W-1:0]. On mismatch, wb_err <= 1 and stays set until flush or reset. The element is still written normally.
- Flush: next cycle wb_valid = 0, fu_done = 0, wb_err = 0, counters = 0, rr_ptr = 0. No grant occurs in the flush cycle. Flush wins over simultaneous valid or wb_ready.
- An element in the output register at flush is discarded.

Test Plan:
- Reset then a single ALU element (vd=3, gidx=32, iter=5, data=0x3F80, mask=1, iter matching cnt after 5 prior accepts) -> next cycle wb_valid=1, wb_we=1, wb_vd=3, wb_elem_idx=37, wb_data=0x3F80, wb_src=0.
- All 5 units valid continuously with wb_ready=1 -> grants cycle 0,1,2,3,4,0. Each fu_ready is one-hot. One write per cycle, no gaps.
- wb_ready=0 for 3 cycles while SQRT holds a result -> wb_* stable, all fu_ready=0. On wb_ready=1 the next grant occurs the same cycle.
- MUL streams 16 elements, iter 0..15, with alternating mask -> wb_we alternates 1/0. fu_done[3] pulses once with iter 15. A further 16 elements give a second pulse; cnt wraps.
- DIV sends iter=0 then iter=2 -> wb_err=1 after the second write and stays set. Flush -> wb_err=0, wb_valid=0, rr_ptr=0.
- gidx=1020, iter=7 with GIDX_W=10 -> wb_elem_idx=3 (wrap). Flush asserted together with fu_valid -> no fu_ready, no write the next cycle.

Source files
------------

// File: rtl/lane_wb_arbiter.sv
// Writeback collector for one vector lane: round-robin arbitration of the
// functional-unit result channels onto a single registered register-file
// write port, with per-unit slice completion pulses and an ordering check.
module lane_wb_arbiter #(
  parameter int unsigned NUM_FU  = 5,
  parameter int unsigned SLICE_W = 16,
  parameter int unsigned ELEM_W  = 16,
  parameter int unsigned VREG_W  = 6,
  parameter int unsigned GIDX_W  = 10,
  parameter int unsigned ITER_W  = $clog2(SLICE_W)
) (
  input  logic                         CLK,
  input  logic                         nRST,
  input  logic                         flush,
  input  logic [NUM_FU-1:0]            fu_valid,
  output logic [NUM_FU-1:0]            fu_ready,
  input  logic [NUM_FU*ELEM_W-1:0]     fu_data,
  input  logic [NUM_FU*VREG_W-1:0]     fu_vd,
  input  logic [NUM_FU*GIDX_W-1:0]     fu_gidx,
  input  logic [NUM_FU*ITER_W-1:0]     fu_iter,
  input  logic [NUM_FU-1:0]            fu_mask,
  output logic                         wb_valid,
  input  logic                         wb_ready,
  output logic                         wb_we,
  output logic [VREG_W-1:0]            wb_vd,
  output logic [GIDX_W-1:0]            wb_elem_idx,
  output logic [ELEM_W-1:0]            wb_data,
  output logic [$clog2(NUM_FU)-1:0]    wb_src,
  output logic [NUM_FU-1:0]            fu_done,
  output logic                         wb_err
);

  localparam int unsigned SRC_W = $clog2(NUM_FU);
  localparam int unsigned CNT_W = ITER_W + 1;

  logic [SRC_W-1:0]  rr_ptr;
  logic [CNT_W-1:0]  cnt [NUM_FU];

  logic              slot_free;
  logic              grant_found;
  logic              accept;
  logic [SRC_W-1:0]  grant_idx;
  logic [ELEM_W-1:0] sel_data;
  logic [VREG_W-1:0] sel_vd;
  logic [GIDX_W-1:0] sel_gidx;
  logic [ITER_W-1:0] sel_iter;
  logic              sel_mask;
  logic [CNT_W-1:0]  sel_cnt;

  assign slot_free = !wb_valid || wb_ready;
  assign accept    = slot_free && !flush && grant_found;

  // Cyclic priority search from rr_ptr, done as two linear passes
  // (units at/above the pointer first, then those below) so every
  // channel select uses a constant index.
  always_comb begin
    grant_found = 1'b0;
    grant_idx   = '0;
    sel_data    = '0;
    sel_vd      = '0;
    sel_gidx    = '0;
    sel_iter    = '0;
    sel_mask    = 1'b0;
    sel_cnt     = '0;
    for (int unsigned pass = 0; pass < 2; pass++) begin
      for (int unsigned k = 0; k < NUM_FU; k++) begin
        if (!grant_found && fu_valid[k] &&
            ((pass == 0) ? (k >= 32'(rr_ptr)) : (k < 32'(rr_ptr)))) begin
          grant_found = 1'b1;
          grant_idx   = SRC_W'(k);
          sel_data    = fu_data[k*ELEM_W +: ELEM_W];
          sel_vd      = fu_vd[k*VREG_W +: VREG_W];
          sel_gidx    = fu_gidx[k*GIDX_W +: GIDX_W];
          sel_iter    = fu_iter[k*ITER_W +: ITER_W];
          sel_mask    = fu_mask[k];
          sel_cnt     = cnt[k];
        end
      end
    end
  end

  // One-hot grant, only when the output slot can take an element.
  always_comb begin
    fu_ready = '0;
    if (slot_free && !flush && grant_found) begin
      fu_ready[grant_idx] = 1'b1;
    end
  end

  // Output register, round-robin pointer, completion counters and error flag.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      wb_valid    <= 1'b0;
      wb_we       <= 1'b0;
      wb_vd       <= '0;
      wb_elem_idx <= '0;
      wb_data     <= '0;
      wb_src      <= '0;
      fu_done     <= '0;
      wb_err      <= 1'b0;
      rr_ptr      <= '0;
      for (int unsigned i = 0; i < NUM_FU; i++) cnt[i] <= '0;
    end else if (flush) begin
      wb_valid <= 1'b0;
      fu_done  <= '0;
      wb_err   <= 1'b0;
      rr_ptr   <= '0;
      for (int unsigned i = 0; i < NUM_FU; i++) cnt[i] <= '0;
    end else begin
      fu_done <= '0;
      if (accept) begin
        wb_valid    <= 1'b1;
        wb_we       <= sel_mask;
        wb_vd       <= sel_vd;
        wb_elem_idx <= sel_gidx + GIDX_W'(sel_iter);
        wb_data     <= sel_data;
        wb_src      <= grant_idx;
        rr_ptr      <= (grant_idx == SRC_W'(NUM_FU - 1)) ? '0 : grant_idx + 1'b1;
        if (sel_cnt == CNT_W'(SLICE_W - 1)) begin
          cnt[grant_idx]     <= '0;
          fu_done[grant_idx] <= 1'b1;
        end else begin
          cnt[grant_idx] <= sel_cnt + 1'b1;
        end
        if (sel_iter != sel_cnt[ITER_W-1:0]) begin
          wb_err <= 1'b1;
        end
      end else if (slot_free) begin
        wb_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_lane_wb_arbiter.sv
// Randomized scoreboard bench for lane_wb_arbiter: a reference model applies
// the arbitration/completion rules each cycle and queues the expected writes;
// a separate monitor pops and compares them at the write handshake.
module tb_lane_wb_arbiter;

  localparam int unsigned NUM_FU  = 5;
  localparam int unsigned SLICE_W = 16;
  localparam int unsigned ELEM_W  = 16;
  localparam int unsigned VREG_W  = 6;
  localparam int unsigned GIDX_W  = 10;
  localparam int unsigned ITER_W  = 4;

  logic                      CLK = 1'b0;
  logic                      nRST;
  logic                      flush;
  logic [NUM_FU-1:0]         fu_valid;
  logic [NUM_FU-1:0]         fu_ready;
  logic [NUM_FU*ELEM_W-1:0]  fu_data;
  logic [NUM_FU*VREG_W-1:0]  fu_vd;
  logic [NUM_FU*GIDX_W-1:0]  fu_gidx;
  logic [NUM_FU*ITER_W-1:0]  fu_iter;
  logic [NUM_FU-1:0]         fu_mask;
  logic                      wb_valid;
  logic                      wb_ready;
  logic                      wb_we;
  logic [VREG_W-1:0]         wb_vd;
  logic [GIDX_W-1:0]         wb_elem_idx;
  logic [ELEM_W-1:0]         wb_data;
  logic [2:0]                wb_src;
  logic [NUM_FU-1:0]         fu_done;
  logic                      wb_err;

  lane_wb_arbiter #(
    .NUM_FU (NUM_FU),
    .SLICE_W(SLICE_W),
    .ELEM_W (ELEM_W),
    .VREG_W (VREG_W),
    .GIDX_W (GIDX_W),
    .ITER_W (ITER_W)
  ) dut (
    .CLK        (CLK),
    .nRST       (nRST),
    .flush      (flush),
    .fu_valid   (fu_valid),
    .fu_ready   (fu_ready),
    .fu_data    (fu_data),
    .fu_vd      (fu_vd),
    .fu_gidx    (fu_gidx),
    .fu_iter    (fu_iter),
    .fu_mask    (fu_mask),
    .wb_valid   (wb_valid),
    .wb_ready   (wb_ready),
    .wb_we      (wb_we),
    .wb_vd      (wb_vd),
    .wb_elem_idx(wb_elem_idx),
    .wb_data    (wb_data),
    .wb_src     (wb_src),
    .fu_done    (fu_done),
    .wb_err     (wb_err)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    logic [ELEM_W-1:0] data;
    logic [VREG_W-1:0] vd;
    logic [GIDX_W-1:0] idx;
    logic              we;
    logic [2:0]        src;
    logic [NUM_FU-1:0] done;
    logic              err;
  } exp_t;

  exp_t sb[$];

  int unsigned passed = 0;
  int unsigned total  = 0;

  // reference model state
  bit          m_valid;
  int          m_rr;
  int          m_cnt [NUM_FU];
  bit          m_err;
  logic [NUM_FU-1:0] exp_ready = '0;
  logic [NUM_FU-1:0] acc = '0;
  bit          flush_prev;
  int unsigned pv, pr, pf, pe;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
  endtask

  // One cycle: drive new inputs after the edge, then advance the model.
  task automatic step();
    int   it;
    int   g;
    exp_t e;
    @(posedge CLK);
    #1;
    if (flush_prev) sb.delete();
    for (int i = 0; i < NUM_FU; i++) begin
      if (!fu_valid[i] || acc[i] || flush_prev) begin
        fu_valid[i]                 = ($urandom_range(99) < pv);
        fu_data[i*ELEM_W +: ELEM_W] = 16'($urandom);
        fu_vd[i*VREG_W +: VREG_W]   = 6'($urandom);
        fu_gidx[i*GIDX_W +: GIDX_W] = 10'($urandom);
        fu_mask[i]                  = 1'($urandom);
        it = m_cnt[i];
        if ($urandom_range(99) < pe) it = (it + 1 + int'($urandom_range(14))) % SLICE_W;
        fu_iter[i*ITER_W +: ITER_W] = 4'(it);
      end
    end
    flush    = ($urandom_range(99) < pf);
    wb_ready = ($urandom_range(99) < pr);

    acc       = '0;
    exp_ready = '0;
    if (flush) begin
      m_valid = 0;
      m_rr    = 0;
      m_err   = 0;
      for (int i = 0; i < NUM_FU; i++) m_cnt[i] = 0;
    end else if (!m_valid || wb_ready) begin
      g = -1;
      for (int k = 0; k < NUM_FU; k++) begin
        int u;
        u = (m_rr + k) % NUM_FU;
        if (g < 0 && fu_valid[u]) g = u;
      end
      if (g >= 0) begin
        e.data = fu_data[g*ELEM_W +: ELEM_W];
        e.vd   = fu_vd[g*VREG_W +: VREG_W];
        e.idx  = 10'((int'(fu_gidx[g*GIDX_W +: GIDX_W]) + int'(fu_iter[g*ITER_W +: ITER_W])) % 1024);
        e.we   = fu_mask[g];
        e.src  = 3'(g);
        e.done = (m_cnt[g] == SLICE_W - 1) ? 5'(1 << g) : 5'b0;
        e.err  = m_err || (int'(fu_iter[g*ITER_W +: ITER_W]) != m_cnt[g]);
        sb.push_back(e);
        m_err        = e.err;
        m_cnt[g]     = (m_cnt[g] + 1) % SLICE_W;
        m_rr         = (g + 1) % NUM_FU;
        m_valid      = 1;
        exp_ready[g] = 1'b1;
        acc[g]       = 1'b1;
      end else begin
        m_valid = 0;
      end
    end
    flush_prev = flush;
  endtask

  // Monitor: grant vector every cycle, done pulse on first appearance,
  // full record at the write handshake.
  bit held = 0;
  always @(negedge CLK) begin
    if (nRST) begin
      check("fu_ready", 32'(fu_ready), 32'(exp_ready));
      if (wb_valid && !held) begin
        if (sb.size() == 0) check("wb_valid_spurious", 32'(wb_valid), 32'd0);
        else check("fu_done_first", 32'(fu_done), 32'(sb[0].done));
      end else begin
        check("fu_done_idle", 32'(fu_done), 32'd0);
      end
      if (wb_valid && wb_ready) begin
        if (sb.size() == 0) begin
          check("wb_handshake_spurious", 32'(wb_valid), 32'd0);
        end else begin
          exp_t e;
          e = sb.pop_front();
          check("wb_data", 32'(wb_data), 32'(e.data));
          check("wb_vd", 32'(wb_vd), 32'(e.vd));
          check("wb_elem_idx", 32'(wb_elem_idx), 32'(e.idx));
          check("wb_we", 32'(wb_we), 32'(e.we));
          check("wb_src", 32'(wb_src), 32'(e.src));
          check("wb_err", 32'(wb_err), 32'(e.err));
        end
      end
      held = wb_valid && !wb_ready && !flush;
    end
  end

  initial begin
    nRST = 1'b0;
    flush = 1'b0;
    wb_ready = 1'b0;
    fu_valid = '0;
    fu_data = '0;
    fu_vd = '0;
    fu_gidx = '0;
    fu_iter = '0;
    fu_mask = '0;
    m_valid = 0;
    m_rr = 0;
    m_err = 0;
    flush_prev = 0;
    for (int i = 0; i < NUM_FU; i++) m_cnt[i] = 0;

    repeat (3) @(posedge CLK);
    @(negedge CLK);
    check("rst_wb_valid", 32'(wb_valid), 32'd0);
    check("rst_wb_we", 32'(wb_we), 32'd0);
    check("rst_wb_vd", 32'(wb_vd), 32'd0);
    check("rst_wb_elem_idx", 32'(wb_elem_idx), 32'd0);
    check("rst_wb_data", 32'(wb_data), 32'd0);
    check("rst_wb_src", 32'(wb_src), 32'd0);
    check("rst_fu_done", 32'(fu_done), 32'd0);
    check("rst_wb_err", 32'(wb_err), 32'd0);
    check("rst_fu_ready", 32'(fu_ready), 32'd0);
    @(posedge CLK);
    #1 nRST = 1'b1;

    for (int ph = 0; ph < 4; ph++) begin
      int len;
      case (ph)
        0:       begin pv = 100; pr = 100; pf = 0; pe = 0; len = 40;   end
        1:       begin pv = 60;  pr = 40;  pf = 0; pe = 0; len = 600;  end
        2:       begin pv = 50;  pr = 80;  pf = 2; pe = 3; len = 1500; end
        default: begin pv = 100; pr = 100; pf = 5; pe = 1; len = 400;  end
      endcase
      for (int c = 0; c < len; c++) step();
    end

    pv = 0; pr = 100; pf = 0; pe = 0;
    for (int c = 0; c < 10; c++) step();
    @(negedge CLK);
    check("sb_drained", 32'(sb.size()), 32'd0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
